rom_arbiter: RTL



---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_arbiter_if.sv | 28 ++
 rtl/rom_arbiter_tag_pipe.sv | 33 +++
 rtl/rom_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types for the ROM arbiter.
//   arb_state_e : arbitration state (open or locked to one owner)
//   tag_t       : per-read tag {valid, id} carried alongside the ROM latency
package rom_arb_pkg;

  localparam int unsigned CNT_W = 8;  // holds burst counts up to 255

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: one requester's read request/response bundle.
//   req_valid/req_addr/req_lock : request from the requester
//   req_ready                   : grant from the arbiter (combinational)
//   rsp_valid/rsp_data          : single-cycle read response
// modport master is the requester side, slave is the arbiter side.
interface rom_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 24
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_lock;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_lock,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_lock,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rom_arbiter_tag_pipe.sv
// tag_pipe: fixed-depth shift register that carries read tags in step with
// the ROM read latency.
//   clk, rst : clock, synchronous active-high reset (clears all tags)
//   tag_in   : tag entering this cycle
//   tag_out  : tag leaving after DEPTH cycles
module tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stage;

  // Shift every cycle; reset drops all reads in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-port synchronous ROM between two requesters.
// Round-robin grant with optional burst locking; each read is tagged and its
// data returned to the issuing requester LATENCY+1 cycles after the grant.
//   clk, rst : clock, synchronous active-high reset
//   req0     : requester 0 bundle (slave side)
//   req1     : requester 1 bundle (slave side)
//   rom_addr : registered ROM address
//   rom_data : ROM read data, passed straight through to rsp_data
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  rom_arbiter_if.slave      req0,
  rom_arbiter_if.slave      req1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);
  localparam logic             CAN_LOCK  = (MAX_BURST > 1);

  arb_state_e       state, state_n;
  logic             owner, owner_n;
  logic [CNT_W-1:0] count, count_n;
  logic             prio, prio_n;
  logic             gnt0, gnt1;
  logic             gnt_lock;
  tag_t             tag_in, tag_out;
  logic             rsp0_q, rsp1_q;

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_OPEN;
      owner <= 1'b0;
      count <= '0;
      prio  <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      count <= count_n;
      prio  <= prio_n;
    end
  end

  // Grant decision and next arbitration state.
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    count_n  = count;
    prio_n   = prio;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    gnt_lock = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB_OPEN: begin
          if (req0.req_valid && (!req1.req_valid || !prio)) begin
            gnt0 = 1'b1;
          end else if (req1.req_valid) begin
            gnt1 = 1'b1;
          end
          gnt_lock = gnt1 ? req1.req_lock : req0.req_lock;
          if (gnt0 || gnt1) begin
            prio_n = gnt0;  // point at the requester not just served
            // A burst cap of 1 means the locking grant is already the last one.
            if (gnt_lock && CAN_LOCK) begin
              state_n = ARB_LOCKED;
              owner_n = gnt1;
              count_n = CNT_W'(1);
            end
          end
        end
        ARB_LOCKED: begin
          gnt0     = !owner && req0.req_valid;
          gnt1     = owner && req1.req_valid;
          gnt_lock = owner ? req1.req_lock : req0.req_lock;
          if (gnt0 || gnt1) begin
            count_n = count + CNT_W'(1);
          end
          // Owner idle, lock released, or cap reached: reopen, favour the other side.
          if (!(gnt0 || gnt1) || !gnt_lock || (count_n >= BURST_CAP)) begin
            state_n = ARB_OPEN;
            prio_n  = !owner;
            count_n = '0;
          end
        end
      endcase
    end
  end

  assign req0.req_ready = gnt0;
  assign req1.req_ready = gnt1;

  // ROM address loads only on a grant so it stays quiet when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
    end else if (gnt0) begin
      rom_addr <= req0.req_addr;
    end else if (gnt1) begin
      rom_addr <= req1.req_addr;
    end
  end

  // Tags ride LATENCY stages here; the response registers below add the
  // final stage so the total matches the address register plus ROM latency.
  assign tag_in = '{valid: gnt0 || gnt1, id: gnt1};

  tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Per-requester response valid, registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
    end else begin
      rsp0_q <= tag_out.valid && !tag_out.id;
      rsp1_q <= tag_out.valid && tag_out.id;
    end
  end

  assign req0.rsp_valid = rsp0_q;
  assign req1.rsp_valid = rsp1_q;
  assign req0.rsp_data  = rom_data;
  assign req1.rsp_data  = rom_data;

endmodule
